// File: rtl/pipeline_hazard_ctrl_if.sv
// -----------------------------------------------------------------------------
// pipeline_hazard_ctrl_if
// Bundles the hazard-detection inputs and the pipeline-control outputs of
// pipeline_hazard_ctrl into a single interface.
//
// Modports:
//   master : pipeline side (decode/EX/MEM status in, controls back)
//   slave  : the hazard controller itself
//
// Signals (direction seen from the slave):
//   id_rs1, id_rs2, id_use_rs1, id_use_rs2  in   ID source-operand info
//   ex_memread, ex_rd                       in   load in EX and its destination
//   ex_branch_taken                         in   branch/jump resolved taken in EX
//   mem_req, mem_ack                        in   data-memory handshake
//   pc_en, *_kick_up                        out  PC / pipeline-register enables
//   if_id_flush, id_ex_flush                out  NOP / bubble strobes
//   mem_timeout                             out  sticky watchdog error
//   stall_cycles, flush_events              out  performance counters
//
// Parameter CNT_W must match the CNT_W of the connected controller.
// -----------------------------------------------------------------------------
interface pipeline_hazard_ctrl_if #(
  parameter int CNT_W = 32
);
  logic [4:0]       id_rs1;
  logic [4:0]       id_rs2;
  logic             id_use_rs1;
  logic             id_use_rs2;
  logic             ex_memread;
  logic [4:0]       ex_rd;
  logic             ex_branch_taken;
  logic             mem_req;
  logic             mem_ack;
  logic             pc_en;
  logic             if_id_kick_up;
  logic             id_ex_kick_up;
  logic             ex_mem_kick_up;
  logic             mem_wb_kick_up;
  logic             if_id_flush;
  logic             id_ex_flush;
  logic             mem_timeout;
  logic [CNT_W-1:0] stall_cycles;
  logic [CNT_W-1:0] flush_events;

  modport master (
    output id_rs1, id_rs2, id_use_rs1, id_use_rs2, ex_memread, ex_rd,
           ex_branch_taken, mem_req, mem_ack,
    input  pc_en, if_id_kick_up, id_ex_kick_up, ex_mem_kick_up, mem_wb_kick_up,
           if_id_flush, id_ex_flush, mem_timeout, stall_cycles, flush_events
  );

  modport slave (
    input  id_rs1, id_rs2, id_use_rs1, id_use_rs2, ex_memread, ex_rd,
           ex_branch_taken, mem_req, mem_ack,
    output pc_en, if_id_kick_up, id_ex_kick_up, ex_mem_kick_up, mem_wb_kick_up,
           if_id_flush, id_ex_flush, mem_timeout, stall_cycles, flush_events
  );
endinterface

// File: rtl/pipeline_hazard_ctrl.sv
// -----------------------------------------------------------------------------
// pipeline_hazard_ctrl
// Sequencer for the PC and the IF/ID, ID/EX, EX/MEM, MEM/WB pipeline registers.
// Resolves load-use stalls, taken-branch flushes and multi-cycle data-memory
// waits. Control outputs are combinational from state and inputs.
//
// Ports:
//   clk    in  clock, rising edge
//   reset  in  asynchronous, active-high; forces every output to 0
//   bus    pipeline_hazard_ctrl_if.slave (hazard inputs, control outputs)
//
// Parameters:
//   FLUSH_CYCLES  IF/ID flush cycles after a taken branch (1..7)
//   MEM_TIMEOUT   MEM_WAIT cycles before mem_timeout sets; 0 disables it
//   CNT_W         performance counter width
//
// Build option: define PIPE_PERF_CNT_EN to implement the stall_cycles and
// flush_events counters; otherwise both ports are tied to 0.
// -----------------------------------------------------------------------------
module pipeline_hazard_ctrl #(
  parameter int FLUSH_CYCLES = 1,
  parameter int MEM_TIMEOUT  = 64,
  parameter int CNT_W        = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  pipeline_hazard_ctrl_if.slave bus
);

  localparam logic [1:0] ST_RUN      = 2'd0;
  localparam logic [1:0] ST_FLUSH    = 2'd1;
  localparam logic [1:0] ST_MEM_WAIT = 2'd2;

  localparam int              WAIT_W      = (MEM_TIMEOUT > 0) ? $clog2(MEM_TIMEOUT + 1) : 1;
  localparam logic [2:0]      FLUSH_INIT  = 3'(FLUSH_CYCLES - 1);
  localparam logic            FLUSH_MULTI = (FLUSH_CYCLES > 1);
  localparam logic [WAIT_W-1:0] TIMEOUT_V = WAIT_W'(MEM_TIMEOUT);

  logic [1:0]        state_r, state_nxt_s;
  logic [1:0]        resume_r, resume_nxt_s;
  logic [1:0]        eff_state_s;
  logic [2:0]        flush_cnt_r, flush_cnt_nxt_s;
  logic [WAIT_W-1:0] wait_cnt_r, wait_cnt_nxt_s, wait_inc_s;
  logic              timeout_r, timeout_nxt_s;
  logic              freeze_s;
  logic              load_use_s;
  logic              pc_en_s, if_id_kick_s, id_ex_kick_s, back_kick_s;
  logic              if_id_flush_s, id_ex_flush_s;

  // Load-use: the load in EX writes a register the ID instruction reads (x0 never hazards).
  always_comb begin
    load_use_s = bus.ex_memread && (bus.ex_rd != 5'd0) &&
                 ((bus.id_use_rs1 && (bus.id_rs1 == bus.ex_rd)) ||
                  (bus.id_use_rs2 && (bus.id_rs2 == bus.ex_rd)));
  end

  // Saturating increment of the memory-wait counter.
  always_comb begin
    if (&wait_cnt_r) begin
      wait_cnt_inc_hold: wait_inc_s = wait_cnt_r;
    end else begin
      wait_inc_s = wait_cnt_r + WAIT_W'(1);
    end
  end

  // Next-state and control-output decode.
  always_comb begin
    state_nxt_s     = state_r;
    resume_nxt_s    = resume_r;
    flush_cnt_nxt_s = flush_cnt_r;
    wait_cnt_nxt_s  = {WAIT_W{1'b0}};
    timeout_nxt_s   = timeout_r;
    pc_en_s         = 1'b0;
    if_id_kick_s    = 1'b0;
    id_ex_kick_s    = 1'b0;
    back_kick_s     = 1'b0;
    if_id_flush_s   = 1'b0;
    id_ex_flush_s   = 1'b0;

    // In MEM_WAIT only the ack releases; once released, the saved state's rules apply.
    case (state_r)
      ST_RUN, ST_FLUSH: begin
        freeze_s    = bus.mem_req && !bus.mem_ack;
        eff_state_s = state_r;
      end
      ST_MEM_WAIT: begin
        freeze_s    = !bus.mem_ack;
        eff_state_s = resume_r;
      end
      default: begin
        freeze_s    = 1'b0;
        eff_state_s = ST_RUN;
      end
    endcase

    if (freeze_s) begin
      state_nxt_s = ST_MEM_WAIT;
      if (state_r == ST_MEM_WAIT) begin
        wait_cnt_nxt_s = wait_inc_s;
        if ((MEM_TIMEOUT != 0) && (wait_inc_s >= TIMEOUT_V)) begin
          timeout_nxt_s = 1'b1;
        end else begin
          timeout_nxt_s = timeout_r;
        end
      end else begin
        resume_nxt_s = state_r;
      end
    end else begin
      case (eff_state_s)
        ST_FLUSH: begin
          // Squash the ID instruction; branch and load-use inputs are ignored.
          pc_en_s       = 1'b1;
          if_id_kick_s  = 1'b1;
          id_ex_kick_s  = 1'b1;
          back_kick_s   = 1'b1;
          if_id_flush_s = 1'b1;
          if (flush_cnt_r <= 3'd1) begin
            state_nxt_s     = ST_RUN;
            flush_cnt_nxt_s = 3'd0;
          end else begin
            state_nxt_s     = ST_FLUSH;
            flush_cnt_nxt_s = flush_cnt_r - 3'd1;
          end
        end
        default: begin
          state_nxt_s  = ST_RUN;
          pc_en_s      = 1'b1;
          if_id_kick_s = 1'b1;
          id_ex_kick_s = 1'b1;
          back_kick_s  = 1'b1;
          if (bus.ex_branch_taken) begin
            if_id_flush_s = 1'b1;
            id_ex_flush_s = 1'b1;
            if (FLUSH_MULTI) begin
              state_nxt_s     = ST_FLUSH;
              flush_cnt_nxt_s = FLUSH_INIT;
            end else begin
              flush_cnt_nxt_s = 3'd0;
            end
          end else if (load_use_s) begin
            // Hold PC and IF/ID, inject a bubble into ID/EX; the load moves on.
            pc_en_s       = 1'b0;
            if_id_kick_s  = 1'b0;
            id_ex_flush_s = 1'b1;
          end else begin
            id_ex_flush_s = 1'b0;
          end
        end
      endcase
    end
  end

  // Controller state registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r     <= ST_RUN;
      resume_r    <= ST_RUN;
      flush_cnt_r <= 3'd0;
      wait_cnt_r  <= {WAIT_W{1'b0}};
      timeout_r   <= 1'b0;
    end else begin
      state_r     <= state_nxt_s;
      resume_r    <= resume_nxt_s;
      flush_cnt_r <= flush_cnt_nxt_s;
      wait_cnt_r  <= wait_cnt_nxt_s;
      timeout_r   <= timeout_nxt_s;
    end
  end

  // Outputs are forced low while reset is asserted.
  assign bus.pc_en          = pc_en_s       & ~reset;
  assign bus.if_id_kick_up  = if_id_kick_s  & ~reset;
  assign bus.id_ex_kick_up  = id_ex_kick_s  & ~reset;
  assign bus.ex_mem_kick_up = back_kick_s   & ~reset;
  assign bus.mem_wb_kick_up = back_kick_s   & ~reset;
  assign bus.if_id_flush    = if_id_flush_s & ~reset;
  assign bus.id_ex_flush    = id_ex_flush_s & ~reset;
  assign bus.mem_timeout    = timeout_r     & ~reset;

`ifdef PIPE_PERF_CNT_EN
  logic [CNT_W-1:0] stall_cnt_r;
  logic [CNT_W-1:0] flush_evt_r;
  logic             flush_evt_s;

  // A branch is accepted when it is decoded in RUN (or on release back to RUN).
  assign flush_evt_s = !freeze_s && (eff_state_s != ST_FLUSH) && bus.ex_branch_taken;

  // Saturating performance counters.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stall_cnt_r <= {CNT_W{1'b0}};
      flush_evt_r <= {CNT_W{1'b0}};
    end else begin
      if (!pc_en_s && !(&stall_cnt_r)) begin
        stall_cnt_r <= stall_cnt_r + CNT_W'(1);
      end else begin
        stall_cnt_r <= stall_cnt_r;
      end
      if (flush_evt_s && !(&flush_evt_r)) begin
        flush_evt_r <= flush_evt_r + CNT_W'(1);
      end else begin
        flush_evt_r <= flush_evt_r;
      end
    end
  end

  assign bus.stall_cycles = stall_cnt_r;
  assign bus.flush_events = flush_evt_r;
`else
  assign bus.stall_cycles = {CNT_W{1'b0}};
  assign bus.flush_events = {CNT_W{1'b0}};
`endif

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// -----------------------------------------------------------------------------
// tb_pipeline_hazard_ctrl
// Self-checking bench for pipeline_hazard_ctrl (FLUSH_CYCLES = 3,
// MEM_TIMEOUT = 8). Directed hazard scenarios followed by randomized traffic,
// all checked against a cycle-level reference model of the sequencing rules.
// -----------------------------------------------------------------------------
module tb_pipeline_hazard_ctrl;
  localparam int FC = 3;
  localparam int MT = 8;
  localparam int CW = 32;

  logic clk = 1'b0;
  logic reset;

  always #5 clk = ~clk;

  pipeline_hazard_ctrl_if #(.CNT_W(CW)) bus ();

  pipeline_hazard_ctrl #(
    .FLUSH_CYCLES(FC),
    .MEM_TIMEOUT (MT),
    .CNT_W       (CW)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: remaining flush cycles, memory-wait bookkeeping, counters.
  int flush_left = 0;
  int wait_len   = 0;
  bit waiting    = 1'b0;
  bit m_timeout  = 1'b0;
  int m_stalls   = 0;
  int m_flushes  = 0;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [63:0] perf(input int v);
`ifdef PIPE_PERF_CNT_EN
    return 64'(v);
`else
    return 64'd0 & 64'(v);
`endif
  endfunction

  // {pc_en, if_id_kick, id_ex_kick, ex_mem_kick, mem_wb_kick, if_id_flush, id_ex_flush}
  function automatic logic [6:0] dut_out();
    return {bus.pc_en, bus.if_id_kick_up, bus.id_ex_kick_up, bus.ex_mem_kick_up,
            bus.mem_wb_kick_up, bus.if_id_flush, bus.id_ex_flush};
  endfunction

  // One clock cycle: check registered state, apply stimulus, check outputs, advance model.
  task automatic drive(input bit rst, input bit req, input bit ack, input bit br,
                       input bit mr, input logic [4:0] rd,
                       input bit u1, input logic [4:0] r1,
                       input bit u2, input logic [4:0] r2);
    logic [6:0] exp;
    bit frozen, lu;
    @(negedge clk);
    check_val("mem_timeout", 64'(bus.mem_timeout), 64'(m_timeout));
    check_val("stall_cycles", 64'(bus.stall_cycles), perf(m_stalls));
    check_val("flush_events", 64'(bus.flush_events), perf(m_flushes));
    reset               = rst;
    bus.mem_req         = req;
    bus.mem_ack         = ack;
    bus.ex_branch_taken = br;
    bus.ex_memread      = mr;
    bus.ex_rd           = rd;
    bus.id_use_rs1      = u1;
    bus.id_rs1          = r1;
    bus.id_use_rs2      = u2;
    bus.id_rs2          = r2;
    #1;
    if (rst) begin
      exp = 7'b0000000;
      flush_left = 0; wait_len = 0; waiting = 1'b0; m_timeout = 1'b0;
      m_stalls = 0; m_flushes = 0;
    end else begin
      frozen = waiting ? !ack : (req && !ack);
      lu = mr && (rd != 5'd0) && ((u1 && r1 == rd) || (u2 && r2 == rd));
      if (frozen) begin
        exp = 7'b0000000;
        if (waiting) begin
          wait_len++;
          if (MT > 0 && wait_len >= MT) m_timeout = 1'b1;
        end
        waiting = 1'b1;
      end else begin
        waiting  = 1'b0;
        wait_len = 0;
        if (flush_left > 0) begin
          exp = 7'b1111110;
          flush_left--;
        end else if (br) begin
          exp = 7'b1111111;
          flush_left = FC - 1;
          m_flushes++;
        end else if (lu) begin
          exp = 7'b0011101;
        end else begin
          exp = 7'b1111100;
        end
      end
      if (!exp[6]) m_stalls++;
    end
    check_val("ctrl_outputs", 64'(dut_out()), 64'(exp));
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0);
  endtask

  task automatic mem(input bit req, input bit ack, input int n);
    for (int i = 0; i < n; i++) drive(1'b0, req, ack, 1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0);
  endtask

  initial begin
    reset = 1'b1;
    bus.mem_req = 1'b0; bus.mem_ack = 1'b0; bus.ex_branch_taken = 1'b0;
    bus.ex_memread = 1'b0; bus.ex_rd = 5'd0; bus.id_use_rs1 = 1'b0; bus.id_rs1 = 5'd0;
    bus.id_use_rs2 = 1'b0; bus.id_rs2 = 5'd0;

    // Reset: all outputs low.
    for (int i = 0; i < 2; i++) drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0);
    // T1: free running.
    idle(3);
    // T2: load-use on rs1, bubble clears it; then on rs2; then ex_rd = 0 gives no stall.
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 5'd5, 1'b1, 5'd5, 1'b0, 5'd7);
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b1, 5'd5, 1'b0, 5'd7);
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 5'd9, 1'b0, 5'd9, 1'b1, 5'd9);
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 5'd0, 1'b1, 5'd0, 1'b1, 5'd0);
    // T3: branch pulse -> three cycles of IF/ID flush.
    drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0);
    idle(4);
    // T4: four frozen cycles, release on the ack.
    mem(1'b1, 1'b0, 4);
    mem(1'b1, 1'b1, 1);
    idle(2);
    // Same-cycle req/ack: no stall.
    mem(1'b1, 1'b1, 2);
    // T6: branch beats load-use, then memory stall in the middle of the flush.
    drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 5'd3, 1'b1, 5'd3, 1'b0, 5'd0);
    mem(1'b1, 1'b0, 2);
    mem(1'b0, 1'b0, 1);
    mem(1'b1, 1'b1, 1);
    idle(3);
    // T5: never acked -> watchdog sets after 8 wait cycles and stays; reset clears it.
    mem(1'b1, 1'b0, 14);
    drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0);
    idle(2);
    // Reset in the middle of a flush.
    drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0);
    drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0);
    idle(2);

    // Randomized traffic with small register numbers to provoke hazards.
    for (int i = 0; i < 3000; i++) begin
      drive(($urandom_range(0, 299) == 0),
            ($urandom_range(0, 3) == 0),
            1'($urandom_range(0, 1)),
            ($urandom_range(0, 7) == 0),
            1'($urandom_range(0, 1)),
            5'($urandom_range(0, 3)),
            1'($urandom_range(0, 1)),
            5'($urandom_range(0, 3)),
            1'($urandom_range(0, 1)),
            5'($urandom_range(0, 3)));
    end
    idle(1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
